// File: rtl/audio_pkg.sv
// Shared types and note-word helpers for the tone sequencer.
// Note word layout is {duration, half_period}.
package audio_pkg;

  localparam int NOTE_HP_W  = 19;
  localparam int NOTE_DUR_W = 8;
  localparam int NOTE_W     = NOTE_HP_W + NOTE_DUR_W;

  localparam logic [NOTE_HP_W-1:0] END_MARKER = {NOTE_HP_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PLAY,
    DONE
  } seq_state_e;

  function automatic logic [NOTE_HP_W-1:0] note_hp(
    input logic [NOTE_W-1:0] w
  );
    return w[NOTE_HP_W-1:0];
  endfunction

  function automatic logic [NOTE_DUR_W-1:0] note_dur(
    input logic [NOTE_W-1:0] w
  );
    return w[NOTE_W-1:NOTE_HP_W];
  endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Control, ROM read and audio write signals of the tone sequencer.
// master = sequencer side, slave = system/ROM side.
interface tone_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int HP_W   = 19,
  parameter int DUR_W  = 8
);
  logic                     start;
  logic                     stop;
  logic [ADDR_W-1:0]        rom_addr;
  logic [HP_W+DUR_W-1:0]    rom_q;
  logic                     audio_out_allowed;
  logic                     write_audio_out;
  logic signed [31:0]       tone_sample;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, stop, rom_q, audio_out_allowed,
    output rom_addr, write_audio_out, tone_sample, busy, done
  );

  modport slave (
    output start, stop, rom_q, audio_out_allowed,
    input  rom_addr, write_audio_out, tone_sample, busy, done
  );
endinterface

// File: rtl/tone_sequencer_tick_gen.sv
// Duration tick divider: one-cycle pulse every TICK_DIV enabled cycles.
// clr holds the phase at zero so every note starts on a fresh tick.
module tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/tone_sequencer.sv
// Plays square-wave notes read from the audio ROM.
// Each word gives a half-period and a duration in ticks.
module tone_sequencer
  import audio_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int HP_W      = NOTE_HP_W,
  parameter int DUR_W     = NOTE_DUR_W,
  parameter int TICK_DIV  = 5_000_000,
  parameter int AMPLITUDE = 10_000_000,
  parameter int ROM_LAT   = 2,
  parameter int LOOP      = 0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  tone_sequencer_if.master sq
);
  localparam int LW = $clog2(ROM_LAT + 2);
  localparam logic [LW-1:0] LAT_LAST = LW'(ROM_LAT);
  localparam logic signed [31:0] AMP_P = 32'(AMPLITUDE);
  localparam logic signed [31:0] AMP_N = -AMP_P;

  seq_state_e         state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [HP_W-1:0]    hp_q;
  logic [HP_W-1:0]    hp_cnt_q;
  logic [HP_W-1:0]    hp_in;
  logic [DUR_W-1:0]   dur_q;
  logic [DUR_W-1:0]   dur_cnt_q;
  logic [DUR_W-1:0]   dur_in;
  logic [DUR_W-1:0]   dur_nx;
  logic [LW-1:0]      lat_q;
  logic               pol_q;
  logic               busy_q;
  logic               done_q;
  logic signed [31:0] tone_q;
  logic               tick;
  logic               hp_wrap;
  logic               pol_nx;

  assign hp_in   = note_hp(sq.rom_q);
  assign dur_in  = note_dur(sq.rom_q);
  assign hp_wrap = (hp_q != '0) && (hp_cnt_q == hp_q - 1'b1);
  assign pol_nx  = pol_q ^ hp_wrap;
  assign dur_nx  = dur_cnt_q + 1'b1;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .clr_i  (state_q != PLAY),
    .en_i   (state_q == PLAY),
    .tick_o (tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      hp_q      <= '0;
      hp_cnt_q  <= '0;
      dur_q     <= '0;
      dur_cnt_q <= '0;
      lat_q     <= '0;
      pol_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tone_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tone_q <= '0;
          if (sq.start && !sq.stop) begin
            state_q <= FETCH;
            addr_q  <= '0;
            lat_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          tone_q <= '0;
          if (sq.stop) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (lat_q != LAT_LAST) begin
            lat_q <= lat_q + 1'b1;
          end else begin
            hp_q  <= hp_in;
            dur_q <= dur_in;
            lat_q <= '0;
            if (hp_in == END_MARKER) begin
              if (LOOP != 0) begin
                addr_q <= '0;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end else if (dur_in == '0) begin
              addr_q <= addr_q + 1'b1;
            end else begin
              state_q   <= PLAY;
              hp_cnt_q  <= '0;
              dur_cnt_q <= '0;
              pol_q     <= 1'b0;
              tone_q    <= (hp_in == '0) ? '0 : AMP_P;
            end
          end
        end
        PLAY: begin
          // the last tick of the note exits so PLAY lasts dur*TICK_DIV cycles
          if (sq.stop) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            tone_q  <= '0;
          end else if (tick && (dur_nx == dur_q)) begin
            state_q <= FETCH;
            addr_q  <= addr_q + 1'b1;
            lat_q   <= '0;
            tone_q  <= '0;
          end else begin
            if (tick) dur_cnt_q <= dur_nx;
            hp_cnt_q <= (hp_wrap || hp_q == '0) ? '0 : hp_cnt_q + 1'b1;
            pol_q    <= pol_nx;
            tone_q   <= (hp_q == '0) ? '0 : (pol_nx ? AMP_N : AMP_P);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          tone_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sq.rom_addr        = addr_q;
  assign sq.tone_sample     = tone_q;
  assign sq.busy            = busy_q;
  assign sq.done            = done_q;
  assign sq.write_audio_out = sq.audio_out_allowed & busy_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: TICK_DIV=4, AMPLITUDE=100, ROM_LAT=2.
// Two instances: one-shot (LOOP=0) and looping (LOOP=1).
module tb_tone_sequencer;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tone_sequencer_if #(.ADDR_W(16), .HP_W(19), .DUR_W(8)) if0 ();
  tone_sequencer_if #(.ADDR_W(16), .HP_W(19), .DUR_W(8)) if1 ();

  tone_sequencer #(
    .TICK_DIV(4), .AMPLITUDE(100), .ROM_LAT(2), .LOOP(0)
  ) dut0 (
    .CLOCK_50 (clk),
    .reset    (reset),
    .sq       (if0)
  );

  tone_sequencer #(
    .TICK_DIV(4), .AMPLITUDE(100), .ROM_LAT(2), .LOOP(1)
  ) dut1 (
    .CLOCK_50 (clk),
    .reset    (reset),
    .sq       (if1)
  );

  // two-cycle latency ROM models
  logic [26:0] rom0 [0:15];
  logic [26:0] rom1 [0:15];
  logic [26:0] r0a, r0b, r1a, r1b;

  always @(posedge clk) begin
    r0a <= rom0[if0.rom_addr[3:0]];
    r0b <= r0a;
    r1a <= rom1[if1.rom_addr[3:0]];
    r1b <= r1a;
  end
  assign if0.rom_q = r0b;
  assign if1.rom_q = r1b;

  function automatic logic [26:0] mk(input int dur, input int hp);
    logic [7:0]  d;
    logic [18:0] h;
    d = 8'(dur);
    h = 19'(hp);
    return {d, h};
  endfunction

  task automatic rom0_clear();
    for (int i = 0; i < 16; i++) rom0[i] = {8'd0, END_MARKER};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, $signed(act), $signed(exp));
    end
  endtask

  typedef struct {
    logic        start;
    logic        stop;
    int          tone;
    logic        busy;
    logic        done;
    int          addr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit s, input bit p, input int tone,
                     input bit b, input bit d, input int a);
    vec_t v;
    v.start = s; v.stop = p; v.tone = tone;
    v.busy = b; v.done = d; v.addr = a;
    tbl.push_back(v);
  endtask

  task automatic run_tbl(input string tag);
    logic al;
    for (int i = 0; i < tbl.size(); i++) begin
      al = 1'($urandom_range(0, 1));
      if0.start = tbl[i].start;
      if0.stop  = tbl[i].stop;
      if0.audio_out_allowed = al;
      step();
      chk($sformatf("%s[%0d].tone", tag, i), if0.tone_sample, tbl[i].tone);
      chk($sformatf("%s[%0d].busy", tag, i), 32'(if0.busy), 32'(tbl[i].busy));
      chk($sformatf("%s[%0d].done", tag, i), 32'(if0.done), 32'(tbl[i].done));
      chk($sformatf("%s[%0d].addr", tag, i), 32'(if0.rom_addr), tbl[i].addr);
      chk($sformatf("%s[%0d].wr", tag, i), 32'(if0.write_audio_out),
          32'(al & tbl[i].busy));
    end
    if0.start = 1'b0;
    if0.stop  = 1'b0;
    tbl.delete();
  endtask

  initial begin
    int done_seen;
    int busy_seen;
    int nchg;
    int found;
    logic [15:0] prev;

    rom0_clear();
    for (int i = 0; i < 16; i++) rom1[i] = {8'd0, END_MARKER};
    if0.start = 0; if0.stop = 0; if0.audio_out_allowed = 1;
    if1.start = 0; if1.stop = 0; if1.audio_out_allowed = 1;
    reset = 1'b1;
    step();
    step();
    chk("rst.tone", if0.tone_sample, 0);
    chk("rst.busy", 32'(if0.busy), 0);
    chk("rst.done", 32'(if0.done), 0);
    chk("rst.addr", 32'(if0.rom_addr), 0);
    chk("rst.wr", 32'(if0.write_audio_out), 0);
    chk("rst1.busy", 32'(if1.busy), 0);
    reset = 1'b0;
    step();

    // one note of 8 cycles, hp=3; start during PLAY is ignored
    rom0[0] = mk(2, 3);
    add(1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 100, 1, 0, 0);
    add(0, 0, 100, 1, 0, 0);
    add(1, 0, 100, 1, 0, 0);
    add(0, 0, -100, 1, 0, 0);
    add(0, 0, -100, 1, 0, 0);
    add(0, 0, -100, 1, 0, 0);
    add(0, 0, 100, 1, 0, 0);
    add(0, 0, 100, 1, 0, 0);
    add(0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1);
    run_tbl("s1");

    // rest note
    rom0_clear();
    rom0[0] = mk(1, 0);
    add(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1);
    run_tbl("s2");

    // zero-duration note skipped, then a 4-cycle note with hp=2
    rom0_clear();
    rom0[0] = mk(0, 5);
    rom0[1] = mk(1, 2);
    add(1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1);
    add(0, 0, 100, 1, 0, 1);
    add(0, 0, 100, 1, 0, 1);
    add(0, 0, -100, 1, 0, 1);
    add(0, 0, -100, 1, 0, 1);
    add(0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 2);
    run_tbl("s3");

    // stop during FETCH
    add(1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0);
    run_tbl("s3stop");

    // reset during PLAY of the second ROM word
    if0.audio_out_allowed = 1'b1;
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("s5.pre.tone", if0.tone_sample, 100);
    chk("s5.pre.addr", 32'(if0.rom_addr), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s5.rst.tone", if0.tone_sample, 0);
    chk("s5.rst.busy", 32'(if0.busy), 0);
    chk("s5.rst.done", 32'(if0.done), 0);
    chk("s5.rst.addr", 32'(if0.rom_addr), 0);
    chk("s5.rst.wr", 32'(if0.write_audio_out), 0);
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (if0.done) done_seen++;
      if (if0.busy) busy_seen++;
    end
    chk("s5.no_done", 32'(done_seen), 0);
    chk("s5.stay_idle", 32'(busy_seen), 0);

    // start and stop together while idle
    if0.start = 1'b1;
    if0.stop  = 1'b1;
    step();
    if0.start = 1'b0;
    if0.stop  = 1'b0;
    chk("s5.ss.busy", 32'(if0.busy), 0);
    step();
    step();
    chk("s5.ss.busy2", 32'(if0.busy), 0);
    chk("s5.ss.done", 32'(if0.done), 0);

    // looping instance
    rom1[0] = mk(1, 2);
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    chk("s4.start.addr", 32'(if1.rom_addr), 0);
    prev = if1.rom_addr;
    nchg = 0;
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (if1.done) done_seen++;
      if (if1.rom_addr != prev) begin
        chk($sformatf("s4.addr_chg%0d", nchg), 32'(if1.rom_addr),
            (nchg % 2 == 0) ? 1 : 0);
        nchg++;
        prev = if1.rom_addr;
      end
    end
    chk("s4.nchg_ge4", 32'(nchg >= 4), 1);
    chk("s4.no_done", 32'(done_seen), 0);
    chk("s4.busy", 32'(if1.busy), 1);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (if1.tone_sample != 0) found = 1;
      else step();
    end
    chk("s4.play_reached", 32'(found), 1);
    if1.stop = 1'b1;
    step();
    if1.stop = 1'b0;
    chk("s4.stop.done", 32'(if1.done), 1);
    chk("s4.stop.tone", if1.tone_sample, 0);
    chk("s4.stop.busy", 32'(if1.busy), 1);
    step();
    chk("s4.idle.busy", 32'(if1.busy), 0);
    chk("s4.idle.done", 32'(if1.done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
